// File: rtl/fan_speed_ctrl.sv
// Fan speed controller: button-driven OFF/LOW/MID/HIGH speed FSM with a
// prescaled 100-step PWM whose duty ramps toward the speed target once per period.
module fan_speed_ctrl #(
    parameter int unsigned PRESCALE  = 1000,
    parameter int unsigned RAMP_STEP = 5,
    parameter int unsigned TGT_LOW   = 30,
    parameter int unsigned TGT_MID   = 60,
    parameter int unsigned TGT_HIGH  = 90
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_speed,
    input  logic       motor_off,
    output logic       motor_sw,
    output logic       pwm_out,
    output logic [2:0] speed_led,
    output logic [6:0] duty
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW = 7;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] CNT_MAX   = DW'(99);
    localparam logic [DW-1:0] DUTY_MAX  = DW'(100);
    localparam logic [DW-1:0] STEP      = DW'((RAMP_STEP > 100) ? 100 : RAMP_STEP);
    localparam logic [DW-1:0] T_LOW     = DW'((TGT_LOW  > 100) ? 100 : TGT_LOW);
    localparam logic [DW-1:0] T_MID     = DW'((TGT_MID  > 100) ? 100 : TGT_MID);
    localparam logic [DW-1:0] T_HIGH    = DW'((TGT_HIGH > 100) ? 100 : TGT_HIGH);

    typedef enum logic [1:0] {S_OFF, S_LOW, S_MID, S_HIGH} state_t;

    state_t          state_q, state_d;
    logic            btn_q, armed_q, btn_pe_q;
    logic            motor_sw_q, motor_sw_d;
    logic [2:0]      led_q, led_d;
    logic [PW-1:0]   presc_q;
    logic [DW-1:0]   cnt_q, duty_q, duty_d, target_c, diff_c;
    logic            pwm_q, tick_c, period_end_c;

    // Button edge detect; armed_q stays low until the button is seen released
    // after reset, so a press held through reset never counts.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            btn_q    <= 1'b0;
            armed_q  <= 1'b0;
            btn_pe_q <= 1'b0;
        end else begin
            btn_q    <= btn_speed;
            btn_pe_q <= btn_speed & ~btn_q & armed_q;
            if (!btn_speed) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q    <= S_OFF;
            motor_sw_q <= 1'b0;
            led_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            motor_sw_q <= motor_sw_d;
            led_q      <= led_d;
        end
    end

    // motor_off has priority over a coincident button edge
    always_comb begin
        state_d    = state_q;
        motor_sw_d = 1'b0;
        led_d      = 3'b000;
        if (motor_off) begin
            state_d = S_OFF;
        end else if (btn_pe_q) begin
            case (state_q)
                S_OFF:   state_d = S_LOW;
                S_LOW:   state_d = S_MID;
                S_MID:   state_d = S_HIGH;
                default: state_d = S_OFF;
            endcase
        end
        motor_sw_d = (state_d != S_OFF);
        case (state_d)
            S_LOW:   led_d = 3'b001;
            S_MID:   led_d = 3'b010;
            S_HIGH:  led_d = 3'b100;
            default: led_d = 3'b000;
        endcase
    end

    assign tick_c       = (presc_q == PRESC_MAX);
    assign period_end_c = tick_c && (cnt_q == CNT_MAX);

    always_comb begin
        case (state_q)
            S_LOW:   target_c = T_LOW;
            S_MID:   target_c = T_MID;
            S_HIGH:  target_c = T_HIGH;
            default: target_c = '0;
        endcase
    end

    // Duty moves at most STEP per period and never past the target
    always_comb begin
        duty_d = duty_q;
        diff_c = '0;
        if (period_end_c) begin
            if (target_c > duty_q) begin
                diff_c = target_c - duty_q;
                duty_d = duty_q + ((diff_c < STEP) ? diff_c : STEP);
            end else if (target_c < duty_q) begin
                diff_c = duty_q - target_c;
                duty_d = duty_q - ((diff_c < STEP) ? diff_c : STEP);
            end
            if (duty_d > DUTY_MAX) duty_d = DUTY_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            presc_q <= '0;
            cnt_q   <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            presc_q <= tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + DW'(1);
            duty_q  <= duty_d;
            pwm_q   <= (cnt_q < duty_q);
        end
    end

    assign motor_sw  = motor_sw_q;
    assign speed_led = led_q;
    assign duty      = duty_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl: expected duty values are queued when a
// speed change is driven and popped at each PWM period end.
module tb_fan_speed_ctrl;

    localparam int unsigned PRESCALE  = 2;
    localparam int unsigned RAMP_STEP = 5;
    localparam int unsigned PERIOD    = 100 * PRESCALE;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       btn_speed;
    logic       motor_off;
    logic       motor_sw;
    logic       pwm_out;
    logic [2:0] speed_led;
    logic [6:0] duty;

    fan_speed_ctrl #(.PRESCALE(PRESCALE), .RAMP_STEP(RAMP_STEP)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .btn_speed (btn_speed),
        .motor_off (motor_off),
        .motor_sw  (motor_sw),
        .pwm_out   (pwm_out),
        .speed_led (speed_led),
        .duty      (duty)
    );

    always #5 clk = ~clk;

    // Clocks since reset release; period end edges are multiples of PERIOD
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= reset_p ? 0 : cyc + 1;

    int          checks   = 0;
    int          failures = 0;
    int          cur_duty = 0;
    int          exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next negedge at which cyc % PERIOD == r
    task automatic wait_mod(input int unsigned r);
        int n = 0;
        @(negedge clk);
        while ((cyc % PERIOD) != r && n < 2 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * PERIOD) chk("wait_timeout", cyc % PERIOD, r);
    endtask

    task automatic push_ramp(input int from, input int to);
        int v = from;
        while (v != to) begin
            if (to > v) v = v + (((to - v) < RAMP_STEP) ? (to - v) : RAMP_STEP);
            else        v = v - (((v - to) < RAMP_STEP) ? (v - to) : RAMP_STEP);
            exp_q.push_back(v);
        end
    endtask

    task automatic drain();
        int e;
        while (exp_q.size() > 0) begin
            wait_mod(PERIOD / 2);
            chk("duty_mid_period", duty, cur_duty);
            wait_mod(0);
            e = exp_q.pop_front();
            chk($sformatf("duty_ramp_%0d", e), duty, e);
            cur_duty = e;
        end
    endtask

    task automatic press();
        @(negedge clk) btn_speed = 1'b1;
        clks(2);
        btn_speed = 1'b0;
        clks(1);
    endtask

    task automatic pwm_high_count(input string tag, input int exp);
        int hi = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            hi += int'(pwm_out);
        end
        chk(tag, hi, exp);
    endtask

    initial begin
        reset_p   = 1'b1;
        btn_speed = 1'b0;
        motor_off = 1'b0;
        clks(3);
        chk("rst_duty", duty, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_motor_sw", motor_sw, 0);
        chk("rst_led", speed_led, 3'b000);
        reset_p = 1'b0;
        clks(4);

        // First press: state follows btn_pe by one clock
        @(negedge clk) btn_speed = 1'b1;
        @(negedge clk);
        chk("sw_at_btn_pe", motor_sw, 0);
        @(negedge clk);
        chk("low_motor_sw", motor_sw, 1);
        chk("low_led", speed_led, 3'b001);
        btn_speed = 1'b0;
        push_ramp(0, 30);
        exp_q.push_back(30);
        drain();
        pwm_high_count("pwm_high_at_30", 60);

        // Target change mid-period: duty holds, then steps from 30
        clks(50);
        press();
        chk("mid_led", speed_led, 3'b010);
        push_ramp(30, 60);
        drain();

        clks(20);
        press();
        chk("high_led", speed_led, 3'b100);
        push_ramp(60, 90);
        drain();

        // motor_off coinciding with btn_pe in HIGH
        clks(20);
        @(negedge clk) btn_speed = 1'b1;
        @(negedge clk) motor_off = 1'b1;
        @(negedge clk) motor_off = 1'b0;
        chk("off_win_high_sw", motor_sw, 0);
        chk("off_win_high_led", speed_led, 3'b000);
        btn_speed = 1'b0;
        push_ramp(90, 0);
        drain();
        pwm_high_count("pwm_high_at_0", 0);

        // motor_off beats btn_pe in LOW (would otherwise go MID)
        press();
        chk("low_again_led", speed_led, 3'b001);
        @(negedge clk) btn_speed = 1'b1;
        @(negedge clk) motor_off = 1'b1;
        @(negedge clk) motor_off = 1'b0;
        chk("off_win_low_led", speed_led, 3'b000);
        chk("off_win_low_sw", motor_sw, 0);
        btn_speed = 1'b0;
        clks(2);

        // Plain motor_off timeout
        press();
        clks(3);
        @(negedge clk) motor_off = 1'b1;
        @(negedge clk) motor_off = 1'b0;
        chk("timeout_led", speed_led, 3'b000);
        chk("timeout_sw", motor_sw, 0);

        // Four presses cycle back to OFF within one period
        press();
        chk("cyc4_low", speed_led, 3'b001);
        press();
        chk("cyc4_mid", speed_led, 3'b010);
        press();
        chk("cyc4_high", speed_led, 3'b100);
        press();
        chk("cyc4_off", speed_led, 3'b000);
        chk("cyc4_off_sw", motor_sw, 0);
        wait_mod(0);
        chk("cyc4_duty", duty, 0);
        pwm_high_count("cyc4_pwm", 0);

        // Reset mid-ramp with the button held across release
        press();
        press();
        push_ramp(0, 45);
        drain();
        clks(30);
        @(negedge clk) begin
            btn_speed = 1'b1;
            reset_p   = 1'b1;
        end
        @(negedge clk);
        chk("rst_ramp_duty", duty, 0);
        chk("rst_ramp_pwm", pwm_out, 0);
        chk("rst_ramp_sw", motor_sw, 0);
        chk("rst_ramp_led", speed_led, 3'b000);
        clks(2);
        reset_p = 1'b0;
        cur_duty = 0;
        clks(20);
        chk("held_thru_rst_led", speed_led, 3'b000);
        chk("held_thru_rst_sw", motor_sw, 0);
        btn_speed = 1'b0;
        clks(2);

        // Long hold advances exactly once
        @(negedge clk) btn_speed = 1'b1;
        clks(10000);
        chk("long_hold_led", speed_led, 3'b001);
        chk("long_hold_duty", duty, 30);
        btn_speed = 1'b0;
        clks(5);
        chk("long_release_led", speed_led, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
